// File: rtl/pixel_pack_out.sv
// pixel_pack_out: packs a valid-only pixel stream into words and buffers them in a FIFO toward a ready/valid sink.
// Define PIXEL_PACK_MSB_FIRST_EN to place the first pixel of a word in the most significant position.
module pixel_pack_out #(
    parameter int DATA_WIDTH   = 1,
    parameter int OUT_WIDTH    = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_flush,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_prog_full,
    output logic                  o_overflow
);
    localparam int K  = OUT_WIDTH / DATA_WIDTH;
    localparam int BW = K > 1 ? $clog2(K) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BW-1:0]        beat, pos;
    logic [OUT_WIDTH-1:0] pack, word;
    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 last, push, pop, full, wr_en;

`ifdef PIXEL_PACK_MSB_FIRST_EN
    assign pos = BW'(K - 1) - beat;
`else
    assign pos = beat;
`endif

    // pack holds zeros in unfilled slots, so a flushed word is padded for free
    assign word  = i_data_valid ? pack | (OUT_WIDTH'(i_data) << (int'(pos) * DATA_WIDTH)) : pack;
    assign last  = i_data_valid && beat == BW'(K - 1);
    assign push  = last || (i_flush && (beat != '0 || i_data_valid));
    assign full  = count == CW'(DEPTH);
    assign pop   = count != '0 && i_data_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            beat       <= '0;
            pack       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            beat   <= push ? '0 : beat + BW'(i_data_valid);
            pack   <= push ? '0 : word;
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(wr_en) - CW'(pop);
            if (push && !wr_en)
                o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn && wr_en)
            mem[wr_ptr] <= word;
    end

    assign o_data_valid = count != '0;
    assign o_data       = o_data_valid ? mem[rd_ptr] : '0;
    assign o_prog_full  = count >= CW'(AFULL_THRESH);
endmodule

// File: doc/pixel_pack_out.md
Name: pixel_pack_out

Overview:
Consumer/output end of the valid-only pixel stream produced by the morphology pipeline registers. Packs DATA_WIDTH-bit pixels into OUT_WIDTH-bit words and buffers them in a small FIFO. Presents the words on a ready/valid output toward the host/DMA side. Raises a programmable almost-full flag so upstream control can stall line feeding, since the input stream has no backpressure.

Parameters:
DATA_WIDTH, 1, input pixel width in bits.
OUT_WIDTH, 8, output word width; must be an integer multiple of DATA_WIDTH; K = OUT_WIDTH/DATA_WIDTH pixels per word.
DEPTH, 16, FIFO capacity in words; power of two, at least 2.
AFULL_THRESH, 12, occupancy at or above which o_prog_full asserts; 1..DEPTH.

Ports:
i_clk  in  1  clock, all logic on rising edge.
i_rstn  in  1  reset, synchronous, active-low.
i_data  in  DATA_WIDTH  pixel.
i_data_valid  in  1  pixel qualifier; every high cycle is one pixel accepted, no backpressure.
i_flush  in  1  single-cycle pulse: zero-pad and emit the partial word.
o_data  out  OUT_WIDTH  head-of-FIFO word; 0 when empty.
o_data_valid  out  1  FIFO non-empty.
i_data_ready  in  1  downstream accepts o_data when high together with o_data_valid.
o_prog_full  out  1  occupancy >= AFULL_THRESH.
o_overflow  out  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (i_rstn=0 at an edge): beat counter, pack register, FIFO pointers and occupancy, and o_overflow all cleared. After the edge: o_data_valid=0, o_data=0, o_prog_full=0, o_overflow=0. Reset mid-word discards the partial word. Reset has priority over all other inputs.
- Packing, default order LSB-first: the pixel at beat b (0..K-1) lands in bits [b*DATA_WIDTH +: DATA_WIDTH]. The beat counter advances only on i_data_valid, so idle gaps are transparent.
- Word completion: the edge sampling the K-th pixel writes the full word (including that pixel) into FIFO memory, and the beat counter wraps to 0. o_data_valid is visible in the cycle after that edge, giving 1-cycle latency from the last pixel.
- Flush: i_flush at an edge with a nonzero partial count (counting any pixel sampled on the same edge) pushes the word zero-padded in the unfilled positions, then clears the beat counter.
- Flush when the beat counter is 0 and no pixel arrives is a no-op.
- Flush on the same edge as the K-th pixel pushes exactly one word.
- Output handshake:
  - A pop occurs at an edge where o_data_valid && i_data_ready.
  - While o_data_valid && !i_data_ready, o_data and o_data_valid hold stable.
  - o_data is a read of mem[rd_ptr], masked to 0 when empty.
- Occupancy: count 0..DEPTH, updated per edge as +push, -pop.
  - Simultaneous push and pop leaves the count unchanged, with pointers both advancing. This is legal at count=DEPTH (the pop frees a slot, no drop) and at count=1.
  - A pop is impossible at count=0.
- Full: a push at count=DEPTH with no simultaneous pop drops the word. Count and memory are unchanged, and o_overflow sets and stays high until reset.
- o_prog_full is derived from the registered count only, with no combinational path from inputs.
- Pointers wrap modulo DEPTH.
- Words leave in strict push order; nothing is duplicated.

Optional Feature:
Macro PIXEL_PACK_MSB_FIRST_EN.
- Defined: packing order is MSB-first; beat b lands in bits [(K-1-b)*DATA_WIDTH +: DATA_WIDTH], and flush zero-pads the low-order positions.
- Undefined: LSB-first as above.
- All other timing and flags are identical.

Test Plan:
- Reset: hold i_rstn=0 for 2 cycles with random inputs -> all outputs 0; after release, o_data_valid stays 0 with no input.
- Pixels 1,0,1,1,0,0,0,1 on 8 consecutive cycles, i_data_ready=1 -> o_data=8'h8D, o_data_valid high for exactly 1 cycle, beginning the cycle after the 8th pixel edge. With PIXEL_PACK_MSB_FIRST_EN defined -> 8'hB1.
- Same 8 pixels with random 0-3 idle cycles between them -> single word 8'h8D, no extra words.
- i_data_ready=0, push 12 words -> o_prog_full=1 after the 12th push edge. Push 17 total -> o_overflow=1, count stays 16. Then set i_data_ready=1 -> 16 words drain in order, 17th absent, o_data_valid low afterwards, o_overflow still 1. Also: at count=16, a push and pop on the same edge -> no drop.
- Pixels 1,1,1 then i_flush -> o_data=8'h07 (MSB-first macro: 8'hE0). i_flush on the same edge as an 8th pixel -> exactly one word. i_flush while idle -> no word.
- 5 pixels of 1, then reset, then 8 pixels of 1 -> exactly one word 8'hFF and no stale partial word.
